// File: rtl/sccb_cfg_pkg.sv
// Shared types and helpers for the SCCB camera configuration sequencer.
// ROM entries are {register, value}; two reserved codes mark END and a long delay.
package sccb_cfg_pkg;

    typedef logic [15:0] rom_entry_t;

    localparam rom_entry_t ENTRY_END   = 16'hFFFF;
    localparam rom_entry_t ENTRY_DELAY = 16'hFFF0;

    typedef enum logic [3:0] {
        ST_BOOT,
        ST_IDLE,
        ST_FETCH,
        ST_START,
        ST_START_WAIT,
        ST_BYTE,
        ST_BYTE_WAIT,
        ST_STOP,
        ST_STOP_WAIT,
        ST_GAP,
        ST_MARK,
        ST_DONE,
        ST_ERROR
    } seq_state_t;

    // Byte 0 is the slave address, then register, then value.
    function automatic logic [7:0] entry_byte(input rom_entry_t entry,
                                              input logic [7:0] slave_addr,
                                              input logic [1:0] sel);
        case (sel)
            2'd0:    entry_byte = slave_addr;
            2'd1:    entry_byte = entry[15:8];
            default: entry_byte = entry[7:0];
        endcase
    endfunction

    // States that wait for cfg_start and therefore neither count nor drive the bus.
    function automatic logic state_parked(input seq_state_t s);
        state_parked = (s == ST_IDLE) || (s == ST_DONE) || (s == ST_ERROR);
    endfunction

    // True on the last cycle of an n-cycle wait; n=0 behaves like n=1.
    function automatic logic count_reached(input logic [31:0] t, input int unsigned n);
        count_reached = ((t + 32'd1) >= n);
    endfunction

endpackage

// File: rtl/ov7670_config_rom.sv
// Camera bring-up register table: registered lookup with one cycle of latency.
// Unused addresses read back as END so a short table terminates cleanly.
module ov7670_config_rom
    import sccb_cfg_pkg::*;
(
    input  logic       clk,
    input  logic [7:0] addr,
    output rom_entry_t data
);

    rom_entry_t entry;

    // Soft reset, let the sensor settle, then the clock prescaler.
    always_comb begin
        case (addr)
            8'd0:    entry = 16'h1280;
            8'd1:    entry = ENTRY_DELAY;
            8'd2:    entry = 16'h1104;
            default: entry = ENTRY_END;
        endcase
    end

    always_ff @(posedge clk) begin
        data <= entry;
    end

endmodule

// File: rtl/sccb_config_seq.sv
// Walks the camera register ROM and drives a byte-level SCCB master through
// START / address / register / value / STOP for each entry.
module sccb_config_seq
    import sccb_cfg_pkg::*;
#(
    parameter logic [7:0]  SLAVE_ADDR = 8'h42,
    parameter int unsigned BOOT_DELAY = 100_000,
    parameter int unsigned GAP_DELAY  = 1_000,
    parameter int unsigned MARK_DELAY = 1_000_000,
    parameter int unsigned TIMEOUT    = 50_000,
    parameter bit          AUTO_START = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cfg_start,
    input  logic       ready,
    input  logic       tx_done,
    output logic       start,
    output logic       stop,
    output logic       i2c_en,
    output logic [7:0] tx_data,
    output logic       busy,
    output logic       cfg_done,
    output logic       cfg_err,
    output logic [7:0] entry_idx
);

    seq_state_t  state;
    seq_state_t  state_next;
    logic [31:0] timer;
    logic [1:0]  byte_cnt;
    logic [1:0]  byte_cnt_next;
    logic [7:0]  idx_next;
    rom_entry_t  rom_q;
    logic        first_cycle;
    logic        watchdog_hit;

    logic        start_d;
    logic        stop_d;
    logic        i2c_en_d;
    logic [7:0]  tx_data_d;
    logic        busy_d;
    logic        cfg_done_d;
    logic        cfg_err_d;

    // Addressed with the next index so the entry is ready during FETCH.
    ov7670_config_rom u_rom (
        .clk  (clk),
        .addr (idx_next),
        .data (rom_q)
    );

    // The master still shows its previous status during the cycle after a command.
    assign first_cycle  = (timer == 32'd0);
    assign watchdog_hit = count_reached(timer, TIMEOUT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_BOOT;
            timer     <= '0;
            byte_cnt  <= '0;
            entry_idx <= '0;
        end else begin
            state     <= state_next;
            byte_cnt  <= byte_cnt_next;
            entry_idx <= idx_next;
            if (state_next != state) begin
                timer <= '0;
            end else if (!state_parked(state)) begin
                timer <= timer + 32'd1;
            end
        end
    end

    always_comb begin
        state_next    = state;
        byte_cnt_next = byte_cnt;
        idx_next      = entry_idx;
        case (state)
            ST_BOOT: begin
                if (count_reached(timer, BOOT_DELAY)) begin
                    state_next = AUTO_START ? ST_FETCH : ST_IDLE;
                end
            end
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (cfg_start) begin
                    state_next = ST_FETCH;
                    idx_next   = 8'd0;
                end
            end
            ST_FETCH: begin
                if (rom_q == ENTRY_END) begin
                    state_next = ST_DONE;
                end else if (rom_q == ENTRY_DELAY) begin
                    state_next = ST_MARK;
                end else begin
                    state_next    = ST_START;
                    byte_cnt_next = 2'd0;
                end
            end
            ST_START: begin
                if (ready) state_next = ST_START_WAIT;
            end
            ST_START_WAIT: begin
                if (watchdog_hit) begin
                    state_next = ST_ERROR;
                end else if (!first_cycle && ready) begin
                    state_next = ST_BYTE;
                end
            end
            ST_BYTE: begin
                state_next = ST_BYTE_WAIT;
            end
            ST_BYTE_WAIT: begin
                if (watchdog_hit) begin
                    state_next = ST_ERROR;
                end else if (!first_cycle && tx_done && ready) begin
                    if (byte_cnt == 2'd2) begin
                        state_next = ST_STOP;
                    end else begin
                        byte_cnt_next = byte_cnt + 2'd1;
                        state_next    = ST_BYTE;
                    end
                end
            end
            ST_STOP: begin
                state_next = ST_STOP_WAIT;
            end
            ST_STOP_WAIT: begin
                if (watchdog_hit) begin
                    state_next = ST_ERROR;
                end else if (!first_cycle && ready) begin
                    state_next = ST_GAP;
                end
            end
            ST_GAP, ST_MARK: begin
                if (count_reached(timer, (state == ST_GAP) ? GAP_DELAY : MARK_DELAY)) begin
                    // A full 256-entry table without END still terminates.
                    if (entry_idx == 8'hFF) begin
                        state_next = ST_DONE;
                    end else begin
                        idx_next   = entry_idx + 8'd1;
                        state_next = ST_FETCH;
                    end
                end
            end
            default: begin
                state_next = ST_BOOT;
            end
        endcase
    end

    // Next values for the registered outputs; strobes last exactly one cycle.
    always_comb begin
        start_d    = (state == ST_START) && ready;
        stop_d     = (state == ST_STOP);
        i2c_en_d   = start_d || stop_d || (state == ST_BYTE);
        tx_data_d  = tx_data;
        if (state == ST_BYTE) begin
            tx_data_d = entry_byte(rom_q, SLAVE_ADDR, byte_cnt);
        end
        case (state_next)
            ST_BOOT:                    busy_d = AUTO_START;
            ST_IDLE, ST_DONE, ST_ERROR: busy_d = 1'b0;
            default:                    busy_d = 1'b1;
        endcase
        cfg_done_d = (state_next == ST_DONE);
        cfg_err_d  = (state_next == ST_ERROR);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start    <= 1'b0;
            stop     <= 1'b0;
            i2c_en   <= 1'b0;
            tx_data  <= 8'h00;
            busy     <= AUTO_START;
            cfg_done <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            start    <= start_d;
            stop     <= stop_d;
            i2c_en   <= i2c_en_d;
            tx_data  <= tx_data_d;
            busy     <= busy_d;
            cfg_done <= cfg_done_d;
            cfg_err  <= cfg_err_d;
        end
    end

endmodule

// File: tb/tb_sccb_config_seq.sv
// Bench for sccb_config_seq: an auto-start and a manual-start instance share one
// behavioural SCCB master; strobes are scored against a queue built from the ROM table.
module tb_sccb_config_seq;

    localparam int BOOT_D = 20;
    localparam int GAP_D  = 5;
    localparam int MARK_D = 60;
    localparam int TMO    = 40;
    localparam int BOUND  = 2000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic rst0, rst1, mreset, sel, nack;
    logic cfg_start0, cfg_start1;
    logic ready, tx_done;

    logic       start0, stop0, en0, busy0, done0, err0;
    logic [7:0] tx0, idx0;
    logic       start1, stop1, en1, busy1, done1, err1;
    logic [7:0] tx1, idx1;

    sccb_config_seq #(
        .SLAVE_ADDR (8'h42), .BOOT_DELAY (BOOT_D), .GAP_DELAY (GAP_D),
        .MARK_DELAY (MARK_D), .TIMEOUT (TMO), .AUTO_START (1'b1)
    ) dut_auto (
        .clk (clk), .reset (rst0), .cfg_start (cfg_start0), .ready (ready),
        .tx_done (tx_done), .start (start0), .stop (stop0), .i2c_en (en0),
        .tx_data (tx0), .busy (busy0), .cfg_done (done0), .cfg_err (err0),
        .entry_idx (idx0)
    );

    sccb_config_seq #(
        .SLAVE_ADDR (8'h42), .BOOT_DELAY (BOOT_D), .GAP_DELAY (GAP_D),
        .MARK_DELAY (MARK_D), .TIMEOUT (TMO), .AUTO_START (1'b0)
    ) dut_manual (
        .clk (clk), .reset (rst1), .cfg_start (cfg_start1), .ready (ready),
        .tx_done (tx_done), .start (start1), .stop (stop1), .i2c_en (en1),
        .tx_data (tx1), .busy (busy1), .cfg_done (done1), .cfg_err (err1),
        .entry_idx (idx1)
    );

    // Only one instance is out of reset at a time; these follow it.
    logic       m_start, m_stop, m_en, m_busy, m_done, m_err;
    logic [7:0] m_tx, m_idx;
    assign m_start = sel ? start1 : start0;
    assign m_stop  = sel ? stop1  : stop0;
    assign m_en    = sel ? en1    : en0;
    assign m_tx    = sel ? tx1    : tx0;
    assign m_busy  = sel ? busy1  : busy0;
    assign m_done  = sel ? done1  : done0;
    assign m_err   = sel ? err1   : err0;
    assign m_idx   = sel ? idx1   : idx0;

    // Behavioural master: every command takes 3 cycles; with nack set the register byte never completes.
    logic [2:0] lat;
    logic       is_byte, hang;
    logic [1:0] pos;
    always @(posedge clk or posedge mreset) begin
        if (mreset) begin
            ready <= 1'b1; tx_done <= 1'b0; lat <= 3'd0;
            is_byte <= 1'b0; hang <= 1'b0; pos <= 2'd0;
        end else if (m_en) begin
            ready   <= 1'b0;
            tx_done <= 1'b0;
            lat     <= 3'd3;
            is_byte <= !m_start && !m_stop;
            hang    <= nack && !m_start && !m_stop && (pos == 2'd1);
            if (m_start) pos <= 2'd0;
            else if (!m_stop) pos <= pos + 2'd1;
        end else if (lat != 3'd0) begin
            lat <= lat - 3'd1;
            if (lat == 3'd1 && !hang) begin
                ready   <= 1'b1;
                tx_done <= is_byte;
            end
        end
    end

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Scoreboard: events are {start, stop, data}; data is ignored for START/STOP.
    logic [9:0] exp_q[$];
    logic [7:0] bytes_seen[$];
    int         start_cyc[$];
    int         stop_cyc[$];
    int         byte_cyc[$];
    int         exp_end_idx;

    logic [15:0] rom_tbl[4]   = '{16'h1280, 16'hFFF0, 16'h1104, 16'hFFFF};
    logic [7:0]  lit_bytes[6] = '{8'h42, 8'h12, 8'h80, 8'h42, 8'h11, 8'h04};

    task automatic clear_obs();
        exp_q.delete();
        bytes_seen.delete();
        start_cyc.delete();
        stop_cyc.delete();
        byte_cyc.delete();
    endtask

    task automatic load_expected();
        exp_end_idx = 255;
        for (int i = 0; i < 4; i++) begin
            if (rom_tbl[i] == 16'hFFFF) begin
                exp_end_idx = i;
                break;
            end
            if (rom_tbl[i] != 16'hFFF0) begin
                exp_q.push_back({2'b10, 8'h00});
                exp_q.push_back({2'b00, 8'h42});
                exp_q.push_back({2'b00, rom_tbl[i][15:8]});
                exp_q.push_back({2'b00, rom_tbl[i][7:0]});
                exp_q.push_back({2'b01, 8'h00});
            end
        end
    endtask

    logic       prev_en  = 1'b0;
    logic [7:0] prev_tx  = 8'h00;
    logic       prev_rst = 1'b1;

    always @(negedge clk) begin
        if (!(sel ? rst1 : rst0)) begin
            if (m_en) begin
                check("strobe", {m_start, m_stop, (m_start || m_stop) ? 8'h00 : m_tx},
                      (exp_q.size() != 0) ? exp_q.pop_front() : 10'h3FF);
                if (m_start) start_cyc.push_back(cyc);
                if (m_stop) stop_cyc.push_back(cyc);
                if (!m_start && !m_stop) begin
                    bytes_seen.push_back(m_tx);
                    byte_cyc.push_back(cyc);
                end
            end
            if (prev_en) check("strobe_width", {31'd0, m_en}, 32'd0);
            if (!m_en && !prev_rst) check("tx_hold", {24'd0, m_tx}, {24'd0, prev_tx});
        end
        prev_en  <= m_en;
        prev_tx  <= m_tx;
        prev_rst <= sel ? rst1 : rst0;
    end

    task automatic check_reset(input logic busy_exp);
        check("rst_start", {31'd0, m_start}, 32'd0);
        check("rst_stop", {31'd0, m_stop}, 32'd0);
        check("rst_i2c_en", {31'd0, m_en}, 32'd0);
        check("rst_tx_data", {24'd0, m_tx}, 32'd0);
        check("rst_busy", {31'd0, m_busy}, {31'd0, busy_exp});
        check("rst_done", {31'd0, m_done}, 32'd0);
        check("rst_err", {31'd0, m_err}, 32'd0);
        check("rst_idx", {24'd0, m_idx}, 32'd0);
    endtask

    task automatic pulse_start(input logic which);
        @(negedge clk);
        if (which) cfg_start1 = 1'b1;
        else cfg_start0 = 1'b1;
        @(negedge clk);
        cfg_start0 = 1'b0;
        cfg_start1 = 1'b0;
    endtask

    task automatic wait_end();
        int n;
        n = 0;
        while (!(m_done || m_err) && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        check("wait_end_in_time", {31'd0, (n < BOUND)}, 32'd1);
    endtask

    task automatic check_run_ok(input string tag);
        check({tag, "_done"}, {31'd0, m_done}, 32'd1);
        check({tag, "_err"}, {31'd0, m_err}, 32'd0);
        check({tag, "_busy"}, {31'd0, m_busy}, 32'd0);
        check({tag, "_idx"}, {24'd0, m_idx}, exp_end_idx);
        check({tag, "_queue_empty"}, exp_q.size(), 32'd0);
        check({tag, "_nbytes"}, bytes_seen.size(), 32'd6);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("%s_byte%0d", tag, i),
                  (i < bytes_seen.size()) ? {24'd0, bytes_seen[i]} : 32'hFFFF_FFFF,
                  {24'd0, lit_bytes[i]});
        end
    endtask

    initial begin
        int rel;
        int n;
        rst0 = 1'b1; rst1 = 1'b1; mreset = 1'b1; sel = 1'b0; nack = 1'b0;
        cfg_start0 = 1'b0; cfg_start1 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset(1'b1);

        // Auto-start run from reset.
        clear_obs();
        load_expected();
        rst0 = 1'b0; mreset = 1'b0; rel = cyc;
        wait_end();
        check_run_ok("boot_run");
        check("boot_latency_min", {31'd0, (start_cyc.size() > 0) && (start_cyc[0] - rel >= BOOT_D)}, 32'd1);
        check("boot_latency_max", {31'd0, (start_cyc.size() > 0) && (start_cyc[0] - rel <= BOOT_D + 6)}, 32'd1);
        check("mark_wait", {31'd0, (start_cyc.size() > 1) && (stop_cyc.size() > 0) &&
                                   (start_cyc[1] - stop_cyc[0] >= MARK_D + GAP_D)}, 32'd1);

        // Replay from DONE; a second pulse mid-run must be ignored.
        clear_obs();
        load_expected();
        pulse_start(1'b0);
        repeat (2) @(negedge clk);
        check("replay_busy", {31'd0, m_busy}, 32'd1);
        check("replay_done_clr", {31'd0, m_done}, 32'd0);
        repeat (30) @(negedge clk);
        pulse_start(1'b0);
        wait_end();
        check_run_ok("replay");

        // Reset while waiting on a byte of entry 2, then a full restart from entry 0.
        clear_obs();
        load_expected();
        pulse_start(1'b0);
        n = 0;
        while (!(m_idx == 8'd2 && m_en && !m_start && !m_stop) && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        check("reach_entry2_byte", {31'd0, (n < BOUND)}, 32'd1);
        #2;
        rst0 = 1'b1; mreset = 1'b1;
        #1;
        check_reset(1'b1);
        repeat (2) @(negedge clk);
        clear_obs();
        load_expected();
        rst0 = 1'b0; mreset = 1'b0;
        wait_end();
        check_run_ok("after_reset");

        // Master stalls on the register byte: watchdog error, then silence.
        clear_obs();
        nack = 1'b1;
        exp_q.push_back({2'b10, 8'h00});
        exp_q.push_back({2'b00, 8'h42});
        exp_q.push_back({2'b00, 8'h12});
        pulse_start(1'b0);
        wait_end();
        check("nack_err", {31'd0, m_err}, 32'd1);
        check("nack_busy", {31'd0, m_busy}, 32'd0);
        check("nack_done", {31'd0, m_done}, 32'd0);
        check("nack_latency", {31'd0, (byte_cyc.size() == 2) &&
                               (cyc - byte_cyc[1] >= TMO) && (cyc - byte_cyc[1] <= TMO + 2)}, 32'd1);
        repeat (100) @(negedge clk);
        check("nack_silent", bytes_seen.size() + start_cyc.size() + stop_cyc.size(), 32'd3);
        check("nack_err_held", {31'd0, m_err}, 32'd1);

        // Recovery from ERROR once the master has been reset.
        nack = 1'b0;
        mreset = 1'b1;
        @(negedge clk);
        mreset = 1'b0;
        clear_obs();
        load_expected();
        pulse_start(1'b0);
        wait_end();
        check_run_ok("recover");

        // Manual-start instance: idle after boot until cfg_start.
        rst0 = 1'b1; mreset = 1'b1;
        @(negedge clk);
        sel = 1'b1;
        repeat (2) @(negedge clk);
        check_reset(1'b0);
        clear_obs();
        rst1 = 1'b0; mreset = 1'b0;
        repeat (BOOT_D + 20) @(negedge clk);
        check("manual_idle_busy", {31'd0, m_busy}, 32'd0);
        check("manual_idle_quiet", start_cyc.size() + bytes_seen.size(), 32'd0);
        load_expected();
        rel = cyc;
        pulse_start(1'b1);
        n = 0;
        while (start_cyc.size() == 0 && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        check("manual_first_start", {31'd0, (start_cyc.size() > 0) && (start_cyc[0] - rel <= 6)}, 32'd1);
        check("manual_busy", {31'd0, m_busy}, 32'd1);
        repeat (10) @(negedge clk);
        pulse_start(1'b1);
        wait_end();
        check_run_ok("manual");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
